// File: rtl/downsampler_slicer_q_pkg.sv
// Shared sizing for the Q-channel decimator/slicer and its I-channel twin.
// Keep these in step with the TX FIR and BER counter widths.
package downsampler_slicer_q_pkg;

    localparam int OS_DEF     = 4;
    localparam int DATA_W_DEF = 8;
    localparam int PH_W_DEF   = $clog2(OS_DEF);
    localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/downsampler_slicer_q_if.sv
// Sample-in / decision-out bundle between the TX FIR and the BER counter.
// With SLICER_SAMPLE_OUT_EN defined the decided sample is exported as o_sample.
interface downsampler_slicer_q_if
    import downsampler_slicer_q_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PH_W   = PH_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic              i_enable;
    logic [DATA_W-1:0] i_sample;
    logic [PH_W-1:0]   i_phase;
    logic              o_bit;
    logic              o_valid;
    logic [CNT_W-1:0]  o_sym_cnt;
`ifdef SLICER_SAMPLE_OUT_EN
    logic [DATA_W-1:0] o_sample;
`endif

    modport master (
        output i_enable, i_sample, i_phase,
`ifdef SLICER_SAMPLE_OUT_EN
        input  o_sample,
`endif
        input  o_bit, o_valid, o_sym_cnt
    );

    modport slave (
        input  i_enable, i_sample, i_phase,
`ifdef SLICER_SAMPLE_OUT_EN
        output o_sample,
`endif
        output o_bit, o_valid, o_sym_cnt
    );

endinterface

// File: rtl/downsampler_slicer_q_symbol_phase_counter.sv
// Mod-OS sample counter plus the active sampling phase, which only changes
// at a symbol boundary so a phase request never skips or repeats a symbol.
module symbol_phase_counter
    import downsampler_slicer_q_pkg::*;
#(
    parameter int OS   = OS_DEF,
    parameter int PH_W = PH_W_DEF
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic [PH_W-1:0] i_phase,
    output logic [PH_W-1:0] o_cnt,
    output logic [PH_W-1:0] o_active_phase
);

    localparam logic [PH_W-1:0] LAST = PH_W'(OS - 1);

    logic [PH_W-1:0] r_cnt;
    logic [PH_W-1:0] r_active_phase;
    logic            w_boundary;
    logic [PH_W-1:0] w_phase_clamped;

    assign w_boundary      = i_enable && (r_cnt == LAST);
    // Only reachable when OS is not a power of two.
    assign w_phase_clamped = (32'(i_phase) > 32'(OS - 1)) ? LAST : i_phase;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_cnt          <= '0;
            r_active_phase <= '0;
        end else begin
            if (i_enable) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
            if (w_boundary) begin
                r_active_phase <= w_phase_clamped;
            end
        end
    end

    assign o_cnt          = r_cnt;
    assign o_active_phase = r_active_phase;

endmodule

// File: rtl/downsampler_slicer_q.sv
// Q-channel symbol-rate decimator and hard-decision slicer (1-cycle latency).
// Optional build macro SLICER_SAMPLE_OUT_EN adds the registered decided sample.
module downsampler_slicer_q
    import downsampler_slicer_q_pkg::*;
#(
    parameter int OS     = OS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PH_W   = PH_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clock,
    input  logic                  i_reset,
    downsampler_slicer_q_if.slave bus
);

    logic [PH_W-1:0]  w_cnt;
    logic [PH_W-1:0]  w_active_phase;
    logic             w_capture;
    logic             r_bit;
    logic             r_valid;
    logic [CNT_W-1:0] r_sym_cnt;

    symbol_phase_counter #(
        .OS   (OS),
        .PH_W (PH_W)
    ) u_phase (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (bus.i_enable),
        .i_phase        (bus.i_phase),
        .o_cnt          (w_cnt),
        .o_active_phase (w_active_phase)
    );

    // Compared against the pre-edge phase, so a boundary-cycle decision uses the old phase.
    assign w_capture = bus.i_enable && (w_cnt == w_active_phase);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_bit     <= 1'b0;
            r_valid   <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_bit     <= bus.i_sample[DATA_W-1];
                r_sym_cnt <= r_sym_cnt + 1'b1;
            end
        end
    end

`ifdef SLICER_SAMPLE_OUT_EN
    logic [DATA_W-1:0] r_sample;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_sample <= '0;
        end else if (w_capture) begin
            r_sample <= bus.i_sample;
        end
    end

    assign bus.o_sample = r_sample;
`endif

    assign bus.o_bit     = r_bit;
    assign bus.o_valid   = r_valid;
    assign bus.o_sym_cnt = r_sym_cnt;

endmodule
